// File: rtl/servant_uart_pkg.sv
// Shared types and constants for the servant UART receiver.
package servant_uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/servant_uart_rx_fifo.sv
// Small synchronous FIFO; simultaneous push and pop are both accepted even when full.
module servant_uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // The extra MSB separates "wrapped once" (full) from "caught up" (empty).
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      // NOTE: state registers use <= so every flop samples pre-edge values.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is left unreset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing/overrun pulses and a valid/ready FIFO.
module servant_uart_rx
  import servant_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 278,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic              i_rx,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_frame_err,
  output logic              o_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

  rx_state_e         state_q;
  logic              rx_meta_q;
  logic              rx_s_q;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              frame_err_q;
  logic              overrun_q;

  logic sample_d;
  logic push_d;
  logic pop_d;
  logic fifo_full;
  logic fifo_empty;

  always_comb begin
    // NOTE: default first so no path through the case leaves sample_d unassigned (no latch).
    sample_d = 1'b0;
    case (state_q)
      ST_START: sample_d = (cnt_q == HALF_LAST);
      ST_DATA,
      ST_STOP:  sample_d = (cnt_q == BIT_LAST);
      default:  sample_d = 1'b0;
    endcase
  end

  assign push_d = (state_q == ST_STOP) && sample_d && rx_s_q;
  assign pop_d  = o_valid && i_ready;

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= i_rx;
      rx_s_q      <= rx_meta_q;
      frame_err_q <= 1'b0;
      overrun_q   <= push_d && fifo_full && !pop_d;
      cnt_q       <= cnt_q + CW'(1);

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q   <= ST_START;
            bit_cnt_q <= '0;
          end
        end
        ST_START: begin
          if (sample_d) begin
            cnt_q   <= '0;
            state_q <= rx_s_q ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (sample_d) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[DATA_W-1:1]};
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == LAST_BIT) state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample_d) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          // A held-low break reports once, then waits for the line to idle.
          cnt_q <= '0;
          if (rx_s_q) state_q <= ST_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  servant_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_i   (wb_clk),
    .rst_n_i (wb_rst_n),
    .push_i  (push_d),
    .data_i  (shift_q),
    .pop_i   (pop_d),
    .data_o  (o_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_valid     = !fifo_empty;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_servant_uart_rx.sv
// Self-checking bench: directed scenarios plus random frames against a byte-queue model.
module tb_servant_uart_rx;

  localparam int CPB       = 16;
  localparam int DEPTH     = 4;
  // Line edge -> 2 sync flops -> idle detect -> half bit -> 8 data bits + stop bit.
  localparam int PUSH_CYC  = 3 + CPB / 2 + 9 * CPB;
  localparam int FRAME_CYC = 10 * CPB;

  logic       wb_clk = 1'b0;
  logic       wb_rst_n;
  logic       i_rx;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         fe_seen = 0, ov_seen = 0, fe_exp = 0, ov_exp = 0, pops = 0;
  bit         mon_en = 1'b0;
  bit         rand_ready_en = 1'b0;
  bit         hold_q = 1'b0;
  logic [7:0] hold_data;

  servant_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .wb_clk      (wb_clk),
    .wb_rst_n    (wb_rst_n),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic drive_line(input logic v, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      i_rx = v;
    end
  endtask

  // Plays one frame; the model decides push/overrun/frame error at the stop-bit sample.
  task automatic send_byte(input logic [7:0] d, input bit stop_ok,
                           input bit ready_pulse, input bit check_lat);
    logic [9:0] fr;
    fr = {stop_ok, d, 1'b0};
    for (int c = 0; c < FRAME_CYC; c++) begin
      tick();
      i_rx = fr[c / CPB];
      if (ready_pulse && c == PUSH_CYC - 1) i_ready = 1'b1;
      if (ready_pulse && c == PUSH_CYC)     i_ready = 1'b0;
      if (check_lat && c == PUSH_CYC - 1) check("valid_before_push", o_valid, 0);
      if (check_lat && c == PUSH_CYC)     check("valid_after_push", o_valid, 1);
      if (c == PUSH_CYC) begin
        if (!stop_ok)                   fe_exp++;
        else if (exp_q.size() < DEPTH)  exp_q.push_back(d);
        else                            ov_exp++;
      end
    end
  endtask

  task automatic check_events(input string tag);
    tick();
    tick();
    check({tag, "_frame_err"}, fe_seen, fe_exp);
    check({tag, "_overrun"}, ov_seen, ov_exp);
  endtask

  task automatic drain(input string tag);
    i_ready = 1'b1;
    for (int k = 0; k < 64 && (exp_q.size() != 0 || o_valid); k++) tick();
    check({tag, "_model_left"}, exp_q.size(), 0);
    check({tag, "_valid_low"}, o_valid, 0);
  endtask

  // Monitor: pulse counting, hold stability and pop-data checks, all mid-cycle.
  always @(negedge wb_clk) begin
    logic [7:0] e;
    if (mon_en) begin
      if (o_frame_err) fe_seen++;
      if (o_overrun)   ov_seen++;
      if (hold_q) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, hold_data);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", o_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", o_data, e);
          pops++;
        end
      end
      hold_q    = o_valid && !i_ready;
      hold_data = o_data;
    end else begin
      hold_q = 1'b0;
    end
  end

  always @(posedge wb_clk) begin
    if (rand_ready_en) begin
      #1;
      i_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int p0;
    wb_rst_n = 1'b0;
    i_rx     = 1'b1;
    i_ready  = 1'b0;
    repeat (3) tick();
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_frame_err", o_frame_err, 0);
    check("rst_overrun", o_overrun, 0);
    wb_rst_n = 1'b1;
    mon_en   = 1'b1;
    drive_line(1'b1, 2 * CPB);

    // Basic byte with ready held high, including push-to-valid latency.
    i_ready = 1'b1;
    send_byte(8'h55, 1'b1, 1'b0, 1'b1);
    check_events("b55");
    drain("b55");

    // Glitch shorter than half a bit must be ignored.
    drive_line(1'b0, 4);
    drive_line(1'b1, 3 * CPB);
    check("glitch_valid", o_valid, 0);
    check_events("glitch");
    send_byte(8'hA3, 1'b1, 1'b0, 1'b0);
    drain("bA3");

    // Bad stop followed by a long break: one frame error, no byte.
    send_byte(8'h41, 1'b0, 1'b0, 1'b0);
    drive_line(1'b0, 40 * CPB);
    drive_line(1'b1, 2 * CPB);
    check_events("break");
    check("break_valid", o_valid, 0);
    send_byte(8'h42, 1'b1, 1'b0, 1'b0);
    drain("b42");
    check_events("after_break");

    // Fill past capacity with the consumer stalled.
    i_ready = 1'b0;
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1, 1'b0, 1'b0);
    check_events("overrun");
    check("full_valid", o_valid, 1);
    check("full_head", o_data, 8'h01);
    drain("overrun");

    // Full FIFO with a pop exactly in the push cycle: no overrun, order kept.
    i_ready = 1'b0;
    for (int b = 0; b < 4; b++) send_byte(8'($urandom), 1'b1, 1'b0, 1'b0);
    send_byte(8'h66, 1'b1, 1'b1, 1'b0);
    check_events("push_pop_full");
    check("push_pop_valid", o_valid, 1);
    p0 = pops;
    drain("push_pop_full");
    check("push_pop_occupancy", pops - p0, 4);

    // Reset during data bit 4 while a byte sits in the FIFO.
    i_ready = 1'b0;
    send_byte(8'h11, 1'b1, 1'b0, 1'b0);
    begin
      logic [9:0] fr;
      fr = {1'b1, 8'h5A, 1'b0};
      for (int c = 0; c < 5 * CPB + CPB / 2; c++) begin
        tick();
        i_rx = fr[c / CPB];
      end
    end
    mon_en   = 1'b0;
    wb_rst_n = 1'b0;
    i_rx     = 1'b1;
    tick();
    tick();
    check("midrst_valid", o_valid, 0);
    check("midrst_data", o_data, 0);
    check("midrst_frame_err", o_frame_err, 0);
    check("midrst_overrun", o_overrun, 0);
    exp_q.delete();
    wb_rst_n = 1'b1;
    drive_line(1'b1, 2 * CPB);
    mon_en  = 1'b1;
    i_ready = 1'b1;
    send_byte(8'h7E, 1'b1, 1'b0, 1'b0);
    check_events("midrst");
    drain("b7E");

    // Random bytes, occasional bad stop bits, random consumer back-pressure.
    rand_ready_en = 1'b1;
    for (int f = 0; f < 12; f++) begin
      logic ok;
      ok = ($urandom_range(0, 5) != 0);
      send_byte(8'($urandom), ok, 1'b0, 1'b0);
      if (!ok) begin
        drive_line(1'b0, $urandom_range(0, 3) * CPB);
        drive_line(1'b1, CPB);
      end
      drive_line(1'b1, $urandom_range(0, 20));
    end
    rand_ready_en = 1'b0;
    tick();
    drain("random");
    check_events("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
